// File: rtl/div_core_arbiter.sv
// div_core_arbiter: round-robin sequencer sharing one iterative divider among
// N_REQ requesters, one job in flight, single tagged response channel.
// Optional macro DIV_ARB_DBZ_BYPASS_EN: zero-divisor jobs are answered directly
// (quotient all ones, remainder = dividend, rsp_dbz = 1) without launching the core.
//
// state | meaning
// IDLE  | searching requesters from the round-robin pointer, accepting one job
// ISSUE | one-cycle core_start pulse, operands held
// WAIT  | divider running, waiting for core_done
// RESP  | result presented and held until rsp_ready
module div_core_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_dividend,
  input  logic [N_REQ*DATA_W-1:0] req_divisor,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_quotient,
  output logic [DATA_W-1:0]       rsp_remainder,
  output logic                    rsp_dbz,
  output logic                    core_start,
  output logic [DATA_W-1:0]       core_dividend,
  output logic [DATA_W-1:0]       core_divisor,
  input  logic                    core_done,
  input  logic [DATA_W-1:0]       core_quotient,
  input  logic [DATA_W-1:0]       core_remainder,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, grant_q;
  logic [ID_W-1:0]   grant_idx, hi_idx, lo_idx;
  logic              grant_found, hi_found;
  logic              accept, rsp_fire, dbz_job;
  logic [DATA_W-1:0] sel_dividend, sel_divisor;

  // Round-robin search: lowest valid index at or above the pointer, else lowest overall (wrap).
  always_comb begin
    hi_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    grant_found = 1'b0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        lo_idx      = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_dividend = req_dividend[i*DATA_W +: DATA_W];
        sel_divisor  = req_divisor[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready is only offered in IDLE, one-hot on the grant, so the handshake completes there.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_found && (grant_idx == ID_W'(i));
    end
  end

  assign accept   = (state_q == IDLE) && grant_found;
  assign rsp_fire = (state_q == RESP) && rsp_ready;

`ifdef DIV_ARB_DBZ_BYPASS_EN
  assign dbz_job = (sel_divisor == '0);
`else
  assign dbz_job = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and state-decoded outputs; core_done outside WAIT is ignored.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE:  if (accept) state_d = dbz_job ? RESP : ISSUE;
      ISSUE: begin
        core_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT:  if (core_done) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job capture, result capture and pointer advance after the response handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ptr_q         <= '0;
      grant_q       <= '0;
      core_dividend <= '0;
      core_divisor  <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
    end else begin
      if (accept) begin
        grant_q       <= grant_idx;
        core_dividend <= sel_dividend;
        core_divisor  <= sel_divisor;
        if (dbz_job) begin
          rsp_id        <= grant_idx;
          rsp_quotient  <= '1;
          rsp_remainder <= sel_dividend;
        end
      end
      if ((state_q == WAIT) && core_done) begin
        rsp_id        <= grant_q;
        rsp_quotient  <= core_quotient;
        rsp_remainder <= core_remainder;
      end
      if (rsp_fire) begin
        ptr_q <= (grant_q == ID_W'(N_REQ-1)) ? '0 : grant_q + ID_W'(1);
      end
    end
  end

`ifdef DIV_ARB_DBZ_BYPASS_EN
  logic dbz_q;

  // Divide-by-zero flag travels with the bypassed response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)      dbz_q <= 1'b0;
    else if (accept)   dbz_q <= dbz_job;
    else if (rsp_fire) dbz_q <= 1'b0;
  end

  assign rsp_dbz = dbz_q;
`else
  assign rsp_dbz = 1'b0;
`endif

endmodule

// File: tb/tb_div_core_arbiter.sv
// Testbench for div_core_arbiter: behavioural divider core, response/grant monitors,
// and a queue/arithmetic reference model of round-robin order and division results.
module tb_div_core_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           tb_ACLK = 1'b0;
  logic           tb_ARESETN;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend;
  logic [N*W-1:0] req_divisor;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_remainder;
  logic           rsp_dbz;
  logic           core_start;
  logic [W-1:0]   core_dividend;
  logic [W-1:0]   core_divisor;
  logic           core_done;
  logic [W-1:0]   core_quotient;
  logic [W-1:0]   core_remainder;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int mptr   = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dbz;
  } rsp_t;

  rsp_t rsp_log[$];
  int   grant_log[$];
  int   start_count = 0;
  int   ready_viol  = 0;

  div_core_arbiter #(.N_REQ(N), .DATA_W(W), .ID_W(IDW)) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
    .busy(busy)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  // Behavioural divider with programmable latency.
  logic [7:0] core_lat = 8'd2;
  logic [7:0] core_cnt;
  logic       core_busy;
  logic [W-1:0] core_a, core_b;
  always @(posedge tb_ACLK or negedge tb_ARESETN) begin
    if (!tb_ARESETN) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= '0;
      core_a    <= '0;
      core_b    <= '0;
      core_quotient  <= '0;
      core_remainder <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
        core_a    <= core_dividend;
        core_b    <= core_divisor;
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          core_busy      <= 1'b0;
          core_done      <= 1'b1;
          core_quotient  <= (core_b == 0) ? '1 : core_a / core_b;
          core_remainder <= (core_b == 0) ? core_a : core_a % core_b;
        end else begin
          core_cnt <= core_cnt - 8'd1;
        end
      end
    end
  end

  // Monitors: response handshakes, accepted grants, launch pulses, ready-rule violations.
  always @(posedge tb_ACLK) begin
    if (tb_ARESETN) begin
      if (core_start) start_count <= start_count + 1;
      if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz});
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      if (req_ready != '0 && (busy || $countones(req_ready) != 1 || (req_ready & ~req_valid) != '0))
        ready_viol <= ready_viol + 1;
    end
  end

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic rsp_t model_rsp(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t e;
    e.id = IDW'(id);
    e.q  = (b == 0) ? '1 : a / b;
    e.r  = (b == 0) ? a : a % b;
`ifdef DIV_ARB_DBZ_BYPASS_EN
    e.dbz = (b == 0);
`else
    e.dbz = 1'b0;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic set_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    int n0;
    n0  = rsp_log.size();
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (rsp_log.size() > n0) got = 1'b1;
    end
  endtask

  task automatic do_reset();
    tb_ARESETN = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    tb_ARESETN = 1'b1;
    tick();
    mptr = 0;
    rsp_log.delete();
    grant_log.delete();
  endtask

  task automatic test_reset();
    tb_ARESETN   = 1'b0;
    req_valid    = '0;
    rsp_ready    = 1'b0;
    req_dividend = '0;
    req_divisor  = '0;
    tick();
    checks++;
    if ({rsp_valid, req_ready, core_start, busy, rsp_id, rsp_quotient, rsp_remainder,
         rsp_dbz, core_dividend, core_divisor} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b ready=%b start=%0b busy=%0b q=%h r=%h, need all 0",
               rsp_valid, req_ready, core_start, busy, rsp_quotient, rsp_remainder);
    end
    tb_ARESETN = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, rsp_valid, req_ready, core_start} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b valid=%0b ready=%b start=%0b, need 0",
               busy, rsp_valid, req_ready, core_start);
    end
  endtask

  task automatic test_single();
    bit got;
    int s0;
    rsp_t exp;
    do_reset();
    core_lat  = 8'd3;
    rsp_ready = 1'b1;
    set_job(1, 32'd100, 32'd7);
    req_valid = 4'b0010;
    s0 = start_count;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_ready: got %b need 0010", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %0b need 1", busy);
    end
    wait_rsp(50, got);
    exp = model_rsp(1, 32'd100, 32'd7);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_timeout: no response within 50 cycles");
    end else if (rsp_log[$] !== exp) begin
      errors++;
      $display("FAIL single_rsp: got id=%0d q=%0d r=%0d need id=%0d q=%0d r=%0d",
               rsp_log[$].id, rsp_log[$].q, rsp_log[$].r, exp.id, exp.q, exp.r);
    end
    checks++;
    if (start_count - s0 != 1) begin
      errors++;
      $display("FAIL single_starts: got %0d core_start pulses need 1", start_count - s0);
    end
  endtask

  task automatic test_fairness();
    logic [W-1:0] op_a[N];
    logic [W-1:0] op_b[N];
    int g;
    rsp_t exp;
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom_range(1, 1000);
      set_job(i, op_a[i], op_b[i]);
    end
    core_lat  = 8'($urandom_range(0, 4));
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 400 && rsp_log.size() < 5; c++) tick();
    req_valid = '0;
    checks++;
    if (rsp_log.size() < 5 || grant_log.size() < 5) begin
      errors++;
      $display("FAIL fair_timeout: got %0d responses %0d grants need 5",
               rsp_log.size(), grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        g = model_grant('1, mptr);
        mptr = (g + 1) % N;
        exp = model_rsp(g, op_a[g], op_b[g]);
        checks++;
        if (grant_log[k] != g) begin
          errors++;
          $display("FAIL fair_order[%0d]: got grant %0d need %0d", k, grant_log[k], g);
        end
        checks++;
        if (rsp_log[k] !== exp) begin
          errors++;
          $display("FAIL fair_rsp[%0d]: got id=%0d q=%h r=%h need id=%0d q=%h r=%h", k,
                   rsp_log[k].id, rsp_log[k].q, rsp_log[k].r, exp.id, exp.q, exp.r);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int bad;
    rsp_t exp;
    do_reset();
    rsp_ready = 1'b0;
    core_lat  = 8'd2;
    for (int i = 1; i < N; i++) set_job(i, 32'd50 + 32'(i), 32'd3);
    set_job(0, 32'hFFFF_FFFF, 32'h10);
    exp = model_rsp(0, 32'hFFFF_FFFF, 32'h10);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_timeout: rsp_valid not seen within 50 cycles");
    end
    req_valid = 4'b1110;
    #1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid !== 1'b1 || rsp_id !== exp.id || rsp_quotient !== exp.q ||
          rsp_remainder !== exp.r || req_ready !== '0) begin
        bad++;
        $display("FAIL bp_stable cycle %0d: got valid=%0b id=%0d q=%h r=%h ready=%b need 1/%0d/%h/%h/0000",
                 c, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, req_ready, exp.id, exp.q, exp.r);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_log.size() != 1) begin
      errors++;
      $display("FAIL bp_release: got valid=%0b handshakes=%0d need 0 and 1", rsp_valid, rsp_log.size());
    end else if (rsp_log[0] !== exp) begin
      errors++;
      $display("FAIL bp_release: got q=%h r=%h need q=%h r=%h", rsp_log[0].q, rsp_log[0].r, exp.q, exp.r);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    int viol;
    rsp_t exp;
    do_reset();
    rsp_ready = 1'b1;
    core_lat  = 8'd20;
    set_job(2, 32'd50, 32'd5);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || core_start !== 1'b0) begin
      errors++;
      $display("FAIL midwait_busy: got busy=%0b start=%0b need 1/0", busy, core_start);
    end
    tb_ARESETN = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, req_ready, core_start, busy, rsp_id, rsp_quotient, rsp_remainder,
         rsp_dbz, core_dividend, core_divisor} !== '0) begin
      errors++;
      $display("FAIL midwait_reset: got valid=%0b busy=%0b start=%0b dividend=%h divisor=%h need all 0",
               rsp_valid, busy, core_start, core_dividend, core_divisor);
    end
    tick();
    tb_ARESETN = 1'b1;
    viol = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (rsp_valid) viol++;
    end
    checks++;
    if (viol != 0 || rsp_log.size() != 0) begin
      errors++;
      $display("FAIL midwait_dropped: got %0d valid cycles %0d responses need 0", viol, rsp_log.size());
    end
    mptr = 0;
    core_lat = 8'd2;
    set_job(0, 32'd9, 32'd3);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midwait_next_ready: got %b need 0001", req_ready);
    end
    tick();
    req_valid = '0;
    wait_rsp(50, got);
    exp = model_rsp(0, 32'd9, 32'd3);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL midwait_next_timeout: no response within 50 cycles");
    end else if (rsp_log[$] !== exp) begin
      errors++;
      $display("FAIL midwait_next: got id=%0d q=%0d r=%0d need id=%0d q=%0d r=%0d",
               rsp_log[$].id, rsp_log[$].q, rsp_log[$].r, exp.id, exp.q, exp.r);
    end
    mptr = 1;
  endtask

  task automatic test_wrap();
    logic [N-1:0] pats[4];
    logic [N-1:0] exp_rdy;
    logic [W-1:0] a, b;
    bit got;
    int g;
    rsp_t exp;
    pats[0] = 4'b0100;
    pats[1] = 4'b0100;
    pats[2] = 4'b1111;
    pats[3] = 4'b0011;
    do_reset();
    rsp_ready = 1'b1;
    core_lat  = 8'd1;
    for (int j = 0; j < 4; j++) begin
      g = model_grant(pats[j], mptr);
      a = $urandom;
      b = $urandom_range(1, 255);
      for (int i = 0; i < N; i++) set_job(i, (i == g) ? a : $urandom, (i == g) ? b : $urandom);
      req_valid = pats[j];
      #1;
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL wrap_grant[%0d]: got ready=%b need %b (ptr %0d)", j, req_ready, exp_rdy, mptr);
      end
      tick();
      req_valid = '0;
      wait_rsp(50, got);
      exp = model_rsp(g, a, b);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL wrap_timeout[%0d]: no response", j);
      end else if (rsp_log[$] !== exp) begin
        errors++;
        $display("FAIL wrap_rsp[%0d]: got id=%0d q=%h r=%h need id=%0d q=%h r=%h", j,
                 rsp_log[$].id, rsp_log[$].q, rsp_log[$].r, exp.id, exp.q, exp.r);
      end
      mptr = (g + 1) % N;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] a[N];
    logic [W-1:0] b[N];
    bit got;
    int g, s0, exp_starts, rsp_bad, rdy_bad;
    rsp_t exp;
    do_reset();
    s0 = start_count;
    exp_starts = 0;
    rsp_bad = 0;
    rdy_bad = 0;
    for (int j = 0; j < 40; j++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        case ($urandom_range(0, 7))
          0:       b[i] = '0;
          1:       b[i] = 32'd1;
          2:       b[i] = $urandom;
          default: b[i] = 32'($urandom_range(1, 5000));
        endcase
        set_job(i, a[i], b[i]);
      end
      core_lat = 8'($urandom_range(0, 5));
      g = model_grant(v, mptr);
      req_valid = v;
      #1;
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      if (req_ready !== exp_rdy) begin
        rdy_bad++;
        $display("FAIL rand_grant[%0d]: got ready=%b need %b (valid %b ptr %0d)", j, req_ready, exp_rdy, v, mptr);
      end
      tick();
      req_valid = '0;
      for (int i = 0; i < N; i++) set_job(i, $urandom, $urandom);
      exp = model_rsp(g, a[g], b[g]);
`ifdef DIV_ARB_DBZ_BYPASS_EN
      if (b[g] != 0) exp_starts++;
`else
      exp_starts++;
`endif
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
        if (rsp_log.size() > j) got = 1'b1;
      end
      if (!got) begin
        rsp_bad++;
        $display("FAIL rand_timeout[%0d]: no response", j);
        break;
      end else if (rsp_log[j] !== exp) begin
        rsp_bad++;
        $display("FAIL rand_rsp[%0d]: got id=%0d q=%h r=%h dbz=%0b need id=%0d q=%h r=%h dbz=%0b", j,
                 rsp_log[j].id, rsp_log[j].q, rsp_log[j].r, rsp_log[j].dbz, exp.id, exp.q, exp.r, exp.dbz);
      end
      mptr = (g + 1) % N;
    end
    rsp_ready = 1'b0;
    checks++;
    if (rdy_bad != 0) errors++;
    checks++;
    if (rsp_bad != 0) errors++;
    checks++;
    if (start_count - s0 != exp_starts) begin
      errors++;
      $display("FAIL rand_starts: got %0d core_start pulses need %0d", start_count - s0, exp_starts);
    end
    checks++;
    if (ready_viol != 0) begin
      errors++;
      $display("FAIL ready_rules: got %0d cycles with illegal req_ready need 0", ready_viol);
    end
  endtask

`ifdef DIV_ARB_DBZ_BYPASS_EN
  task automatic test_dbz();
    int s0;
    rsp_t exp;
    do_reset();
    rsp_ready = 1'b0;
    set_job(0, 32'h1234, 32'h0);
    exp = model_rsp(0, 32'h1234, 32'h0);
    s0 = start_count;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dbz !== 1'b1 || rsp_quotient !== exp.q || rsp_remainder !== exp.r) begin
      errors++;
      $display("FAIL dbz_rsp: got valid=%0b dbz=%0b q=%h r=%h need 1/1/%h/%h",
               rsp_valid, rsp_dbz, rsp_quotient, rsp_remainder, exp.q, exp.r);
    end
    checks++;
    if (start_count != s0) begin
      errors++;
      $display("FAIL dbz_no_start: got %0d core_start pulses need 0", start_count - s0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid_wait();
    test_wrap();
`ifdef DIV_ARB_DBZ_BYPASS_EN
    test_dbz();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
